accum_overflow_ctrl: RTL and testbench

- Sequencing controller for the 8-bit signed add/sub datapath and its overflow detection.
- Loads an initial accumulator value, then accepts a programmed number of signed operands over a valid/ready stream and adds or subtracts each one.
- Checks every step for two's-complement overflow and returns the final result over a valid/ready output handshake.
- Sits between a stimulus/control source and downstream result consumers in the adder/subtractor lab datapath.

---
 rtl/accum_overflow_ctrl_if.sv | 30 +++
 rtl/accum_overflow_ctrl.sv | 100 ++++++++++
 tb/tb_accum_overflow_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/accum_overflow_ctrl_if.sv
// Stream/control bundle between the accumulator controller and its source/consumer.
// master drives operands and start; slave (the controller) returns the result.
interface accum_overflow_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] init;
    logic [CNT_W-1:0] count;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_data;
    logic             op_sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             busy;

    modport master (
        output start, init, count, op_valid, op_data, op_sub, res_ready,
        input  op_ready, res_valid, result, ovf, ovf_count, busy
    );

    modport slave (
        input  start, init, count, op_valid, op_data, op_sub, res_ready,
        output op_ready, res_valid, result, ovf, ovf_count, busy
    );
endinterface

// File: rtl/accum_overflow_ctrl.sv
// Signed add/sub accumulator sequencer with two's-complement overflow tracking.
// Define ACCUM_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module accum_overflow_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    accum_overflow_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ovfc_q, ovfc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sum;
    logic             a_msb, b_msb, s_msb;
    logic             v;

    assign sum   = bus.op_sub ? acc_q - bus.op_data : acc_q + bus.op_data;
    assign a_msb = acc_q[WIDTH-1];
    assign b_msb = bus.op_data[WIDTH-1];
    assign s_msb = sum[WIDTH-1];
    assign v     = bus.op_sub ? ((a_msb != b_msb) && (s_msb != a_msb))
                              : ((a_msb == b_msb) && (s_msb != a_msb));

`ifdef ACCUM_SATURATE_EN
    logic [WIDTH-1:0] clamp;
    // Overflow direction follows the sign of the accumulator before the step.
    assign clamp = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            ovfc_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            ovfc_q  <= ovfc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        ovfc_d  = ovfc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.init;
                    rem_d   = bus.count;
                    ovf_d   = 1'b0;
                    ovfc_d  = '0;
                    state_d = (bus.count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.op_valid) begin
`ifdef ACCUM_SATURATE_EN
                    acc_d = v ? clamp : sum;
`else
                    acc_d = sum;
`endif
                    rem_d = rem_q - 1'b1;
                    if (v) begin
                        ovf_d = 1'b1;
                        if (ovfc_q != '1) ovfc_d = ovfc_q + 1'b1;
                    end
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.op_ready  = (state_q == ACCUM);
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.ovf_count = ovfc_q;
endmodule

// File: tb/tb_accum_overflow_ctrl.sv
// Scoreboard bench for accum_overflow_ctrl: integer reference model feeds an
// expected-result queue that a monitor drains on each result handshake.
module tb_accum_overflow_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        int res;
        int ov;
        int oc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   op_tab[16];
    bit   sub_tab[16];

    accum_overflow_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    accum_overflow_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int s8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    // Reference: plain integer arithmetic, overflow = true result outside [-128,127].
    function automatic exp_t model(input int ini, input int cnt);
        exp_t e;
        int acc, full;
        acc = ini;
        e.ov = 0;
        e.oc = 0;
        for (int i = 0; i < cnt; i++) begin
            full = sub_tab[i] ? acc - op_tab[i] : acc + op_tab[i];
            if (full > 127 || full < -128) begin
                e.ov = 1;
                if (e.oc < 15) e.oc++;
`ifdef ACCUM_SATURATE_EN
                acc = (full > 127) ? 127 : -128;
`else
                acc = (full > 127) ? full - 256 : full + 256;
`endif
            end else begin
                acc = full;
            end
        end
        e.res = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", s8(bus.result), e.res);
                chk("ovf", int'(bus.ovf), e.ov);
                chk("ovf_count", int'(bus.ovf_count), e.oc);
            end
        end
    end

    task automatic run(input int ini, input int cnt, input int gap,
                       input int hold, input bit poke);
        logic [7:0] r0;
        sb.push_back(model(ini, cnt));
        @(posedge clk) #1;
        bus.start = 1'b1;
        bus.init  = 8'(ini);
        bus.count = 4'(cnt);
        @(posedge clk) #1;
        bus.start = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            chk("op_ready", int'(bus.op_ready), 1);
            bus.op_valid = 1'b1;
            bus.op_data  = 8'(op_tab[i]);
            bus.op_sub   = sub_tab[i];
            @(posedge clk) #1;
            bus.op_valid = 1'b0;
            bus.op_data  = 8'($urandom);
            if (i != cnt - 1)
                repeat (gap) begin
                    @(posedge clk) #1;
                end
        end
        chk("res_valid_latency", int'(bus.res_valid), 1);
        chk("busy_done", int'(bus.busy), 1);
        r0 = bus.result;
        for (int k = 0; k < hold; k++) begin
            bus.start = poke;
            bus.init  = 8'($urandom);
            bus.count = 4'($urandom);
            @(posedge clk) #1;
            bus.start = 1'b0;
            chk("hold_valid", int'(bus.res_valid), 1);
            chk("hold_result", int'(bus.result), int'(r0));
        end
        bus.res_ready = 1'b1;
        @(posedge clk) #1;
        bus.res_ready = 1'b0;
        chk("res_valid_drop", int'(bus.res_valid), 0);
        chk("idle_result", int'(bus.result), int'(r0));
    endtask

    task automatic set_ops(input int n, input int a0, input bit s0,
                           input int a1, input bit s1, input int a2, input bit s2);
        op_tab[0] = a0; sub_tab[0] = s0;
        op_tab[1] = a1; sub_tab[1] = s1;
        op_tab[2] = a2; sub_tab[2] = s2;
        for (int i = n; i < 16; i++) begin
            op_tab[i] = 0;
            sub_tab[i] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op_ready"}, int'(bus.op_ready), 0);
        chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_result"}, int'(bus.result), 0);
        chk({tag, "_ovf"}, int'(bus.ovf), 0);
        chk({tag, "_ovf_count"}, int'(bus.ovf_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.init = '0;
        bus.count = '0;
        bus.op_valid = 1'b0;
        bus.op_data = '0;
        bus.op_sub = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        set_ops(3, 10, 0, 20, 0, 30, 0);
        run(0, 3, 0, 0, 0);
        set_ops(1, 1, 0, 0, 0, 0, 0);
        run(127, 1, 0, 0, 0);
        set_ops(2, 2, 1, 5, 0, 0, 0);
        run(-127, 2, 0, 0, 0);
        set_ops(0, 0, 0, 0, 0, 0, 0);
        run(-5, 0, 0, 3, 1);
        set_ops(3, 7, 1, -3, 0, 100, 0);
        run(20, 3, 2, 3, 1);
        set_ops(1, -128, 1, 0, 0, 0, 0);
        run(0, 1, 0, 0, 0);

        // Abort a 3-operand run after the first transfer.
        @(posedge clk) #1;
        bus.start = 1'b1;
        bus.init = 8'(50);
        bus.count = 4'(3);
        @(posedge clk) #1;
        bus.start = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_data = 8'(100);
        bus.op_sub = 1'b0;
        @(posedge clk) #1;
        bus.op_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        chk_zero("midrst");
        set_ops(2, 100, 0, 100, 0, 0, 0);
        run(50, 2, 1, 1, 0);

        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                op_tab[i] = ($urandom_range(0, 3) == 0)
                          ? (($urandom_range(0, 1) == 1) ? 127 : -128)
                          : int'($urandom_range(0, 255)) - 128;
                sub_tab[i] = 1'($urandom);
            end
            run(int'($urandom_range(0, 255)) - 128, n,
                $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        @(posedge clk) #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
